// File: rtl/result_serializer.sv
// result_serializer
// Serial result port for the full-search block-matching engine.
// {coordinate, mad} words are queued in a small FIFO and shifted out one bit
// per clock on s_out_port, framed by s_out_valid and s_out_sof. Consecutive
// queued words are sent with no idle cycle between them.

module result_serializer #(
    parameter int COORD_W   = 8,
    parameter int MAD_W     = 12,
    parameter int DEPTH     = 4,
    parameter int LSB_FIRST = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [COORD_W-1:0]           coordinate,
    input  logic [MAD_W-1:0]             mad,
    input  logic                         en_input,
    output logic                         in_ready,
    output logic                         s_out_port,
    output logic                         s_out_valid,
    output logic                         s_out_sof,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow
);

    localparam int W  = COORD_W + MAD_W;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(W);

    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [BW-1:0] LOAD_CNT  = BW'(W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // FIFO storage and bookkeeping
    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    // Serializer state
    state_t        r_state;
    logic [W-1:0]  r_shift;
    logic [BW-1:0] r_bit_cnt;
    logic          r_port;
    logic          r_valid;
    logic          r_sof;

    logic          w_ready;
    logic          w_push;
    logic          w_word_done;
    logic          w_pop;
    logic [W-1:0]  w_head;

    // A full FIFO refuses pushes even if a pop happens on the same edge.
    assign w_ready     = (r_count != FULL_CNT);
    assign w_push      = en_input && w_ready;
    // The serializer can take a new word when idle or while its last bit is on the pin.
    assign w_word_done = (r_state == IDLE) || (r_bit_cnt == '0);
    assign w_pop       = (r_count != '0) && w_word_done;
    assign w_head      = r_mem[r_rd_ptr];

    assign in_ready    = w_ready;
    assign s_out_port  = r_port;
    assign s_out_valid = r_valid;
    assign s_out_sof   = r_sof;
    assign fifo_count  = r_count;
    assign overflow    = r_overflow;

    // FIFO data array: written on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {coordinate, mad};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag: any push attempted while full sets it until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (en_input && !w_ready) begin
            r_overflow <= 1'b1;
        end
    end

    // Serializer FSM: load a word and emit its first bit, then shift out the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_port    <= 1'b0;
            r_valid   <= 1'b0;
            r_sof     <= 1'b0;
        end else begin
            if (w_pop) begin
                // New word: first bit goes straight to the pin, the rest waits in r_shift.
                if (LSB_FIRST != 0) begin
                    r_port  <= w_head[0];
                    r_shift <= w_head >> 1;
                end else begin
                    r_port  <= w_head[W-1];
                    r_shift <= w_head << 1;
                end
                r_valid   <= 1'b1;
                r_sof     <= 1'b1;
                r_bit_cnt <= LOAD_CNT;
                r_state   <= SHIFT;
            end else if (r_state == SHIFT && r_bit_cnt != '0) begin
                // Mid-word: move the next bit to the pin.
                if (LSB_FIRST != 0) begin
                    r_port  <= r_shift[0];
                    r_shift <= r_shift >> 1;
                end else begin
                    r_port  <= r_shift[W-1];
                    r_shift <= r_shift << 1;
                end
                r_sof     <= 1'b0;
                r_bit_cnt <= r_bit_cnt - BW'(1);
            end else begin
                // Nothing queued after the last bit (or already idle).
                r_port    <= 1'b0;
                r_valid   <= 1'b0;
                r_sof     <= 1'b0;
                r_state   <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: an MSB-first and an LSB-first instance share the
// same stimulus and are compared every cycle against a queue-based model of the
// serial stream, plus directed checks with fixed expected values.

module tb_result_serializer;

    localparam int COORD_W = 8;
    localparam int MAD_W   = 12;
    localparam int DEPTH   = 4;
    localparam int W       = COORD_W + MAD_W;
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int VW      = 10 + 2 * CW;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [COORD_W-1:0] coordinate;
    logic [MAD_W-1:0]   mad;
    logic               en_input;

    logic          m_ready, m_port, m_valid, m_sof, m_ovf;
    logic [CW-1:0] m_count;
    logic          l_ready, l_port, l_valid, l_sof, l_ovf;
    logic [CW-1:0] l_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    result_serializer #(.COORD_W(COORD_W), .MAD_W(MAD_W), .DEPTH(DEPTH), .LSB_FIRST(0)) u_msb (
        .clk(clk), .rst_n(rst_n), .coordinate(coordinate), .mad(mad), .en_input(en_input),
        .in_ready(m_ready), .s_out_port(m_port), .s_out_valid(m_valid), .s_out_sof(m_sof),
        .fifo_count(m_count), .overflow(m_ovf)
    );

    result_serializer #(.COORD_W(COORD_W), .MAD_W(MAD_W), .DEPTH(DEPTH), .LSB_FIRST(1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .coordinate(coordinate), .mad(mad), .en_input(en_input),
        .in_ready(l_ready), .s_out_port(l_port), .s_out_valid(l_valid), .s_out_sof(l_sof),
        .fifo_count(l_count), .overflow(l_ovf)
    );

    logic [VW-1:0] dut_vec;
    assign dut_vec = {m_valid, m_sof, m_port, l_valid, l_sof, l_port,
                      m_count, l_count, m_ready, l_ready, m_ovf, l_ovf};

    // Reference model: a word queue plus the word currently on the wire.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_cur;
    int           m_idx;
    int           m_left;
    logic         e_valid, e_sof, e_ovf;

    // Serial-word recorder fed from the MSB-first output.
    logic [W-1:0] rec_word;
    int           rec_n;
    logic [W-1:0] rec_q[$];

    function automatic logic [VW-1:0] exp_vec();
        logic p, lp, r;
        logic [CW-1:0] c;
        p  = e_valid ? m_cur[W-1-m_idx] : 1'b0;
        lp = e_valid ? m_cur[m_idx] : 1'b0;
        c  = CW'(mq.size());
        r  = (mq.size() != DEPTH);
        return {e_valid, e_sof, p, e_valid, e_sof, lp, c, c, r, r, e_ovf, e_ovf};
    endfunction

    task automatic model_clear();
        mq.delete();
        m_cur   = '0;
        m_idx   = 0;
        m_left  = 0;
        e_valid = 1'b0;
        e_sof   = 1'b0;
        e_ovf   = 1'b0;
    endtask

    // Drive one cycle of input, advance the model across the edge, settle 1 time unit.
    task automatic tick(input bit en, input logic [W-1:0] word);
        bit do_push, do_pop;
        en_input = en;
        {coordinate, mad} = word;
        @(posedge clk);
        do_pop  = (m_left == 0) && (mq.size() != 0);
        do_push = en && (mq.size() < DEPTH);
        if (en && !do_push) e_ovf = 1'b1;
        if (do_pop) begin
            m_cur   = mq.pop_front();
            m_idx   = 0;
            m_left  = W - 1;
            e_valid = 1'b1;
            e_sof   = 1'b1;
        end else if (m_left > 0) begin
            m_idx++;
            m_left--;
            e_sof = 1'b0;
        end else begin
            e_valid = 1'b0;
            e_sof   = 1'b0;
        end
        if (do_push) mq.push_back(word);
        #1;
    endtask

    task automatic record();
        if (m_valid) begin
            if (m_sof) begin
                rec_word = '0;
                rec_n    = 0;
            end
            rec_word = {rec_word[W-2:0], m_port};
            rec_n++;
            if (rec_n == W) rec_q.push_back(rec_word);
        end
    endtask

    task automatic test_reset();
        en_input   = 1'b0;
        coordinate = '0;
        mad        = '0;
        rst_n      = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, '0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got %b exp %b", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if ({m_valid, m_port, m_count, m_ready, m_ovf} !== {1'b0, 1'b0, CW'(0), 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got v%b p%b c%0d r%b o%b exp v0 p0 c0 r1 o0",
                     m_valid, m_port, m_count, m_ready, m_ovf);
        end
    endtask

    task automatic test_single_word();
        logic [W-1:0] got_m, got_l;
        int sof_cnt, sof_edge;
        bit last_valid;
        got_m = '0; got_l = '0; sof_cnt = 0; sof_edge = -1; last_valid = 1'b0;
        tick(1'b1, 20'hA53C7);
        for (int e = 1; e <= 21; e++) begin
            tick(1'b0, '0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL single_cyc edge %0d got %b exp %b", e, dut_vec, exp_vec());
            end
            if (e <= 20) begin
                got_m[W-e] = m_port;
                got_l[W-e] = l_port;
            end
            if (e == 20) last_valid = m_valid && l_valid;
            if (m_sof) begin
                sof_cnt++;
                sof_edge = e;
            end
        end
        checks++;
        if (got_m !== 20'hA53C7) begin
            errors++;
            $display("FAIL msb_stream got %h exp a53c7", got_m);
        end
        checks++;
        if (got_l !== 20'hE3CA5) begin
            errors++;
            $display("FAIL lsb_stream got %h exp e3ca5", got_l);
        end
        checks++;
        if (sof_cnt != 1 || sof_edge != 1) begin
            errors++;
            $display("FAIL single_sof got count %0d edge %0d exp count 1 edge 1", sof_cnt, sof_edge);
        end
        checks++;
        if (last_valid !== 1'b1 || m_valid !== 1'b0 || l_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_valid_end got at20 %b at21 %b/%b exp 1 then 0/0",
                     last_valid, m_valid, l_valid);
        end
    endtask

    task automatic test_back_to_back();
        int nvalid, first, last, sof_cnt;
        bit sof1, sof21;
        nvalid = 0; first = -1; last = -1; sof_cnt = 0; sof1 = 0; sof21 = 0;
        tick(1'b1, 20'h00001);
        for (int e = 1; e <= 42; e++) begin
            if (e == 1) tick(1'b1, 20'hFFFFF);
            else        tick(1'b0, '0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_cyc edge %0d got %b exp %b", e, dut_vec, exp_vec());
            end
            if (m_valid) begin
                nvalid++;
                if (first < 0) first = e;
                last = e;
            end
            if (m_sof) begin
                sof_cnt++;
                if (e == 1)  sof1  = 1;
                if (e == 21) sof21 = 1;
            end
        end
        checks++;
        if (nvalid != 40 || first != 1 || last != 40) begin
            errors++;
            $display("FAIL b2b_valid got n %0d first %0d last %0d exp 40 1 40", nvalid, first, last);
        end
        checks++;
        if (sof_cnt != 2 || !sof1 || !sof21) begin
            errors++;
            $display("FAIL b2b_sof got count %0d at1 %0d at21 %0d exp 2 1 1", sof_cnt, sof1, sof21);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] w[6];
        int exp_cnt[6] = '{1, 1, 2, 3, 4, 4};
        rec_q.delete();
        rec_n = 0;
        for (int i = 0; i < 6; i++) w[i] = W'($urandom);
        for (int e = 0; e < 6; e++) begin
            tick(1'b1, w[e]);
            record();
            checks++;
            if (m_count !== CW'(exp_cnt[e])) begin
                errors++;
                $display("FAIL ovf_count edge %0d got %0d exp %0d", e, m_count, exp_cnt[e]);
            end
            if (e == 4) begin
                checks++;
                if (m_ready !== 1'b0 || m_ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_full edge 4 got ready %b ovf %b exp 0 0", m_ready, m_ovf);
                end
            end
            if (e == 5) begin
                checks++;
                if (m_ovf !== 1'b1 || l_ovf !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_flag edge 5 got %b/%b exp 1/1", m_ovf, l_ovf);
                end
            end
        end
        for (int e = 6; e < 110; e++) begin
            tick(1'b0, '0);
            record();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL ovf_cyc edge %0d got %b exp %b", e, dut_vec, exp_vec());
            end
        end
        checks++;
        if (rec_q.size() != 5) begin
            errors++;
            $display("FAIL ovf_words got %0d words exp 5", rec_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (rec_q[i] !== w[i]) begin
                    errors++;
                    $display("FAIL ovf_order word %0d got %h exp %h", i, rec_q[i], w[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midword();
        logic [W-1:0] nw;
        int sof_edge;
        for (int e = 0; e < 3; e++) tick(1'b1, W'($urandom));
        for (int e = 3; e <= 7; e++) tick(1'b0, '0);
        checks++;
        if (m_count !== CW'(2) || m_valid !== 1'b1 || m_ovf !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got count %0d valid %b ovf %b exp 2 1 1", m_count, m_valid, m_ovf);
        end
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if ({m_valid, m_sof, m_port, l_valid, l_sof, l_port, m_count, m_ovf} !== '0) begin
            errors++;
            $display("FAIL async_reset got v%b s%b p%b lv%b ls%b lp%b c%0d o%b exp all 0",
                     m_valid, m_sof, m_port, l_valid, l_sof, l_port, m_count, m_ovf);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL post_reset got %b exp %b", dut_vec, exp_vec());
        end
        nw = W'($urandom);
        sof_edge = -1;
        tick(1'b1, nw);
        for (int e = 1; e <= 22; e++) begin
            tick(1'b0, '0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL post_reset_cyc edge %0d got %b exp %b", e, dut_vec, exp_vec());
            end
            if (m_sof && sof_edge < 0) sof_edge = e;
        end
        checks++;
        if (sof_edge != 1) begin
            errors++;
            $display("FAIL post_reset_sof got edge %0d exp 1", sof_edge);
        end
    endtask

    task automatic test_random();
        int pct;
        for (int i = 0; i < 600; i++) begin
            pct = (i < 200) ? 8 : (i < 400) ? 40 : 95;
            tick(($urandom_range(0, 99) < pct), W'($urandom));
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random_cyc %0d got %b exp %b", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_overflow();
        test_reset_midword();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
